// File: rtl/sobel_edge_filter.sv
// sobel_edge_filter
//   Streaming 3x3 Sobel edge filter. Each accepted RGB444 pixel is reduced to
//   a 6-bit gray level (R + 2G + B, 0..60), pushed through two line buffers
//   and a 3x3 window, and |Gx|+|Gy| of the post-shift window is thresholded.
//   The result for the window centre (x-1, y-1) is registered on the same
//   edge that accepts (x, y), with column/row wrap at x==0 / y==0.
//
//   Build option: define SOBEL_MAG_OUT_EN to emit a gray magnitude
//   {m4,m4,m4}, m4 = min(mag>>2, 15), instead of 12'hFFF for edge pixels.
//   Sub-threshold, border and pre-start results stay 12'h000 either way.
//
// Ports
//   clk            pixel clock
//   reset          synchronous, active-high
//   vga_ready      accept strobe (pipeline advances only on accept)
//   video_in       RGB444 pixel {R,G,B} at (x_count, y_count)
//   x_count        input column
//   y_count        input row
//   filtered_video edge result for (x_out, y_out)
//   x_out, y_out   coordinates of the result on filtered_video
//   valid_out      one-cycle strobe marking a new result
module sobel_edge_filter #(
  parameter int unsigned WIDTH     = 640,
  parameter int unsigned HEIGHT    = 480,
  parameter logic [8:0]  THRESHOLD = 9'd96
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_ready,
  input  logic [11:0] video_in,
  input  logic [9:0]  x_count,
  input  logic [8:0]  y_count,
  output logic [11:0] filtered_video,
  output logic [9:0]  x_out,
  output logic [8:0]  y_out,
  output logic        valid_out
);

  localparam int         AW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [9:0] XMAX = 10'(WIDTH - 1);
  localparam logic [8:0] YMAX = 9'(HEIGHT - 1);

  logic          w_accept;
  logic [AW-1:0] w_addr;
  logic [5:0]    w_gray;
  logic [5:0]    w_lb0_rd;
  logic [5:0]    w_lb1_rd;
  logic [5:0]    r_lb0 [WIDTH];
  logic [5:0]    r_lb1 [WIDTH];
  logic [5:0]    r_win [3][3];
  logic [5:0]    w_win [3][3];
  logic [7:0]    w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
  logic [7:0]    w_abs_gx, w_abs_gy;
  logic [8:0]    w_mag;
  logic [9:0]    w_cx;
  logic [8:0]    w_cy;
  logic          w_border;
  logic [11:0]   w_on_pix;
  logic [11:0]   w_pix;
  logic          r_started;
  logic [11:0]   r_video;
  logic [9:0]    r_x;
  logic [8:0]    r_y;
  logic          r_valid;

  assign w_accept = vga_ready && (x_count <= XMAX) && (y_count <= YMAX);
  assign w_addr   = x_count[AW-1:0];
  assign w_gray   = {2'b00, video_in[11:8]} + {1'b0, video_in[7:4], 1'b0} + {2'b00, video_in[3:0]};
  // Asynchronous read gives the pre-write contents on the accepting edge.
  assign w_lb0_rd = r_lb0[w_addr];
  assign w_lb1_rd = r_lb1[w_addr];

  // Line buffers: row y-1 moves down to row y-2, current gray becomes row y-1.
  always_ff @(posedge clk) begin
    if (w_accept && !reset) begin
      r_lb1[w_addr] <= w_lb0_rd;
      r_lb0[w_addr] <= w_gray;
    end
  end

  // Next window: shift columns left and load {lb1, lb0, gray} on the right.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_win[r][0] = r_win[r][1];
      w_win[r][1] = r_win[r][2];
      w_win[r][2] = 6'd0;
    end
    w_win[0][2] = w_lb1_rd;
    w_win[1][2] = w_lb0_rd;
    w_win[2][2] = w_gray;
  end

  // Window register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= 6'd0;
        end
      end
    end else if (w_accept) begin
      r_win <= w_win;
    end
  end

  // Gradients are formed as |pos - neg| so no signed arithmetic is needed.
  assign w_gx_pos = {2'b00, w_win[0][2]} + {1'b0, w_win[1][2], 1'b0} + {2'b00, w_win[2][2]};
  assign w_gx_neg = {2'b00, w_win[0][0]} + {1'b0, w_win[1][0], 1'b0} + {2'b00, w_win[2][0]};
  assign w_gy_pos = {2'b00, w_win[2][0]} + {1'b0, w_win[2][1], 1'b0} + {2'b00, w_win[2][2]};
  assign w_gy_neg = {2'b00, w_win[0][0]} + {1'b0, w_win[0][1], 1'b0} + {2'b00, w_win[0][2]};
  assign w_abs_gx = (w_gx_pos >= w_gx_neg) ? (w_gx_pos - w_gx_neg) : (w_gx_neg - w_gx_pos);
  assign w_abs_gy = (w_gy_pos >= w_gy_neg) ? (w_gy_pos - w_gy_neg) : (w_gy_neg - w_gy_pos);
  assign w_mag    = {1'b0, w_abs_gx} + {1'b0, w_abs_gy};

  // Centre trails the input by one column and one row, wrapping at 0.
  assign w_cx     = (x_count == 10'd0) ? XMAX : (x_count - 10'd1);
  assign w_cy     = (y_count == 9'd0) ? YMAX : (y_count - 9'd1);
  assign w_border = (w_cx == 10'd0) || (w_cx == XMAX) || (w_cy == 9'd0) || (w_cy == YMAX);

`ifdef SOBEL_MAG_OUT_EN
  logic [3:0] w_m4;
  assign w_m4     = (w_mag[8:2] > 7'd15) ? 4'hF : w_mag[5:2];
  assign w_on_pix = {w_m4, w_m4, w_m4};
`else
  assign w_on_pix = 12'hFFF;
`endif

  assign w_pix = ((w_mag > THRESHOLD) && r_started && !w_border) ? w_on_pix : 12'h000;

  // Output stage and start tracking; everything but valid holds without accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_video   <= 12'h000;
      r_x       <= 10'd0;
      r_y       <= 9'd0;
      r_valid   <= 1'b0;
      r_started <= 1'b0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_video <= w_pix;
        r_x     <= w_cx;
        r_y     <= w_cy;
        if ((x_count == 10'd0) && (y_count == 9'd0)) begin
          r_started <= 1'b1;
        end
      end
    end
  end

  assign filtered_video = r_video;
  assign x_out          = r_x;
  assign y_out          = r_y;
  assign valid_out      = r_valid;

endmodule

// File: tb/tb_sobel_edge_filter.sv
// tb_sobel_edge_filter
//   Drives raster frames into sobel_edge_filter (reduced 16x12 geometry) and
//   compares every cycle against a frame-image reference: expected output of
//   a centre is the Sobel magnitude taken directly from the stored picture.
module tb_sobel_edge_filter;

  localparam int W = 16;
  localparam int H = 12;
`ifdef SOBEL_MAG_OUT_EN
  localparam logic [8:0]  THR     = 9'd16;
  localparam logic [11:0] STEP_HI = 12'h222;
  localparam logic [11:0] STEP_ON = 12'h888;
`else
  localparam logic [8:0]  THR     = 9'd96;
  localparam logic [11:0] STEP_HI = 12'hFFF;
  localparam logic [11:0] STEP_ON = 12'hFFF;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        vga_ready = 1'b0;
  logic [11:0] video_in = 12'h000;
  logic [9:0]  x_count = 10'd0;
  logic [8:0]  y_count = 9'd0;
  logic [11:0] filtered_video;
  logic [9:0]  x_out;
  logic [8:0]  y_out;
  logic        valid_out;

  int n_err = 0;
  int n_checks = 0;

  logic [11:0] img [H][W];
  logic [11:0] src [H][W];
  bit          m_started = 1'b0;
  logic [11:0] e_v = 12'h000;
  int          e_x = 0;
  int          e_y = 0;
  logic        e_valid = 1'b0;
  int          on_count = 0;
  bit          on_bad = 1'b0;

  sobel_edge_filter #(.WIDTH(W), .HEIGHT(H), .THRESHOLD(THR)) dut (
    .clk(clk), .reset(reset), .vga_ready(vga_ready), .video_in(video_in),
    .x_count(x_count), .y_count(y_count), .filtered_video(filtered_video),
    .x_out(x_out), .y_out(y_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  function automatic int gray(input int x, input int y);
    logic [11:0] p;
    p = img[y][x];
    return int'(p[11:8]) + 2 * int'(p[7:4]) + int'(p[3:0]);
  endfunction

  function automatic logic [11:0] model_pix(input int cx, input int cy);
    int gx, gy, mag, m;
    logic [3:0] m4;
    if (!m_started || cx == 0 || cx == W - 1 || cy == 0 || cy == H - 1) return 12'h000;
    gx = (gray(cx+1, cy-1) + 2*gray(cx+1, cy) + gray(cx+1, cy+1))
       - (gray(cx-1, cy-1) + 2*gray(cx-1, cy) + gray(cx-1, cy+1));
    gy = (gray(cx-1, cy+1) + 2*gray(cx, cy+1) + gray(cx+1, cy+1))
       - (gray(cx-1, cy-1) + 2*gray(cx, cy-1) + gray(cx+1, cy-1));
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (mag <= int'(THR)) return 12'h000;
`ifdef SOBEL_MAG_OUT_EN
    m = mag / 4;
    if (m > 15) m = 15;
    m4 = 4'(m);
    return {m4, m4, m4};
`else
    m = 0;
    m4 = 4'(m);
    return 12'hFFF;
`endif
  endfunction

  // One clock with the given inputs, then compare all outputs to the model.
  task automatic drive(input logic rdy, input int x, input int y, input logic [11:0] pix);
    bit acc;
    acc = rdy && (x < W) && (y < H);
    vga_ready = rdy;
    x_count   = 10'(x);
    y_count   = 9'(y);
    video_in  = pix;
    if (acc) begin
      img[y][x] = pix;
      e_x = (x == 0) ? W - 1 : x - 1;
      e_y = (y == 0) ? H - 1 : y - 1;
      e_v = model_pix(e_x, e_y);
      if (x == 0 && y == 0) m_started = 1'b1;
    end
    e_valid = acc;
    @(posedge clk);
    #1;
    n_checks++;
    if (valid_out !== e_valid) begin
      n_err++;
      $display("FAIL valid_out in(%0d,%0d) rdy=%b: got %b exp %b", x, y, rdy, valid_out, e_valid);
    end
    n_checks++;
    if (x_out !== 10'(e_x)) begin
      n_err++;
      $display("FAIL x_out in(%0d,%0d): got %0d exp %0d", x, y, x_out, e_x);
    end
    n_checks++;
    if (y_out !== 9'(e_y)) begin
      n_err++;
      $display("FAIL y_out in(%0d,%0d): got %0d exp %0d", x, y, y_out, e_y);
    end
    n_checks++;
    if (filtered_video !== e_v) begin
      n_err++;
      $display("FAIL filtered_video centre(%0d,%0d): got %h exp %h", e_x, e_y, filtered_video, e_v);
    end
    if (acc && filtered_video !== 12'h000) begin
      on_count++;
      if (filtered_video !== STEP_ON || !(e_x == W/2 - 1 || e_x == W/2)) on_bad = 1'b1;
    end
  endtask

  // Idle cycle: either no ready, or ready with coordinates outside the frame.
  task automatic idle();
    if ($urandom_range(0, 1) == 0)
      drive(1'b0, $urandom_range(0, W - 1), $urandom_range(0, H - 1), 12'($urandom));
    else
      drive(1'b1, W + $urandom_range(0, 100), $urandom_range(0, H - 1), 12'($urandom));
  endtask

  task automatic stream_rows(input int y0, input bit gaps);
    for (int y = y0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (gaps) begin
          while ($urandom_range(0, 1) == 1) idle();
        end
        drive(1'b1, x, y, src[y][x]);
      end
    end
  endtask

  task automatic stream_frame(input bit gaps);
    stream_rows(0, gaps);
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    vga_ready = 1'b1;
    x_count   = 10'd3;
    y_count   = 9'd3;
    video_in  = 12'hFFF;
    repeat (3) @(posedge clk);
    #1;
    m_started = 1'b0;
    e_x = 0; e_y = 0; e_v = 12'h000; e_valid = 1'b0;
    n_checks++;
    if (filtered_video !== 12'h000 || x_out !== 10'd0 || y_out !== 9'd0 || valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got v=%h x=%0d y=%0d valid=%b exp 000/0/0/0",
               filtered_video, x_out, y_out, valid_out);
    end
    reset     = 1'b0;
    vga_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_uniform();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) src[y][x] = 12'h777;
    for (int f = 0; f < 2; f++) begin
      on_count = 0;
      stream_frame(1'b0);
      n_checks++;
      if (on_count != 0) begin
        n_err++;
        $display("FAIL uniform_nonzero frame %0d: got %0d exp 0", f, on_count);
      end
    end
  endtask

  task automatic test_step();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) src[y][x] = (x < W/2) ? 12'h000 : STEP_HI;
    stream_frame(1'b0);
    on_count = 0;
    on_bad   = 1'b0;
    stream_frame(1'b0);
    n_checks++;
    if (on_count != 2 * (H - 2) || on_bad) begin
      n_err++;
      $display("FAIL step_edges: got count=%0d bad=%b exp count=%0d bad=0", on_count, on_bad, 2*(H-2));
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 0, 1, 12'($urandom));
    n_checks++;
    if (x_out !== 10'(W-1) || y_out !== 9'd0 || filtered_video !== 12'h000) begin
      n_err++;
      $display("FAIL wrap_0_1: got (%0d,%0d,%h) exp (%0d,0,000)", x_out, y_out, filtered_video, W-1);
    end
    drive(1'b1, 0, 0, 12'($urandom));
    n_checks++;
    if (x_out !== 10'(W-1) || y_out !== 9'(H-1) || filtered_video !== 12'h000) begin
      n_err++;
      $display("FAIL wrap_0_0: got (%0d,%0d,%h) exp (%0d,%0d,000)", x_out, y_out, filtered_video, W-1, H-1);
    end
    drive(1'b1, 1, 1, 12'($urandom));
    n_checks++;
    if (x_out !== 10'd0 || y_out !== 9'd0 || filtered_video !== 12'h000) begin
      n_err++;
      $display("FAIL wrap_1_1: got (%0d,%0d,%h) exp (0,0,000)", x_out, y_out, filtered_video);
    end
  endtask

  task automatic fill_random();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        src[y][x] = ($urandom_range(0, 3) == 0) ? 12'($urandom) : (($urandom_range(0, 1) == 0) ? 12'h111 : 12'hCCC);
  endtask

  task automatic test_random_gaps();
    for (int f = 0; f < 3; f++) begin
      fill_random();
      stream_frame(1'b1);
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      fill_random();
      stream_frame(1'b0);
    end
  endtask

  task automatic test_reset_midframe();
    fill_random();
    stream_rows(0, 1'b0);
    for (int x = 0; x < 5; x++) drive(1'b1, x, 0, src[0][x]);
    apply_reset();
    stream_rows(H/2, 1'b0);
    fill_random();
    stream_frame(1'b0);
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_step();
    test_wrap();
    test_random_gaps();
    test_back_to_back();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
